// File: rtl/jtag_seq_master_if.sv
// Command/response handshake bundle for jtag_seq_master.
// The slave modport is the sequencer side; master is the command issuer.
interface jtag_seq_master_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_type;
    logic [3:0]  cmd_len;
    logic [15:0] cmd_data;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_data;

    modport master (output cmd_valid, cmd_type, cmd_len, cmd_data, rsp_ready,
                    input  cmd_ready, rsp_valid, rsp_data);
    modport slave  (input  cmd_valid, cmd_type, cmd_len, cmd_data, rsp_ready,
                    output cmd_ready, rsp_valid, rsp_data);
endinterface

// File: rtl/jtag_seq_master.sv
// JTAG TAP sequencer: runs DR/IR scans of 1..16 bits from a command and returns captured TDO.
// Optional macro JTAG_SEQ_RESET_CMD_EN turns cmd_type=1x into a TAP reset sequence (else a NOP).
module jtag_seq_master (
    input  logic             TCK,
    input  logic             TRST_b,
    jtag_seq_master_if.slave bus,
    output logic             TMS,
    output logic             TDI,
    input  logic             TDO,
    output logic             busy
);
    typedef enum logic [3:0] {
        INIT, IDLE, SEL_DR, SEL_IR, CAPTURE, SHIFT, EXIT1, UPDATE, RSP
`ifdef JTAG_SEQ_RESET_CMD_EN
        , RST_SEQ
`endif
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        ir_q, ir_d;
    logic [3:0]  len_q, len_d;
    logic [15:0] data_q, data_d;
    logic [15:0] rsp_data_q, rsp_data_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        cmd_ready_q, cmd_ready_d;
    logic        tms_q, tms_d;
    logic        tdi_q, tdi_d;
    logic        busy_q, busy_d;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ir_d       = ir_q;
        len_d      = len_q;
        data_d     = data_q;
        rsp_data_d = rsp_data_q;

        case (state_q)
            INIT: begin
                if (cnt_q == 4'd5) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            IDLE: begin
                if (bus.cmd_valid && cmd_ready_q) begin
                    ir_d       = bus.cmd_type[0];
                    len_d      = bus.cmd_len;
                    data_d     = bus.cmd_data;
                    rsp_data_d = '0;
                    cnt_d      = '0;
                    if (bus.cmd_type[1]) begin
`ifdef JTAG_SEQ_RESET_CMD_EN
                        state_d = RST_SEQ;
`else
                        state_d = RSP;
`endif
                    end else begin
                        state_d = SEL_DR;
                    end
                end
            end
            SEL_DR:  state_d = ir_q ? SEL_IR : CAPTURE;
            SEL_IR:  state_d = CAPTURE;
            // Two TMS=0 cycles: target moves SELECT->CAPTURE->SHIFT
            CAPTURE: begin
                if (cnt_q == 4'd1) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            SHIFT: begin
                rsp_data_d[cnt_q] = TDO;
                if (cnt_q == len_q) begin
                    state_d = EXIT1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            EXIT1:   state_d = UPDATE;
            UPDATE:  state_d = RSP;
            RSP: begin
                if (rsp_valid_q && bus.rsp_ready) state_d = IDLE;
            end
`ifdef JTAG_SEQ_RESET_CMD_EN
            RST_SEQ: begin
                if (cnt_q == 4'd5) begin
                    state_d = RSP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
`endif
            default: begin
                state_d = INIT;
                cnt_d   = '0;
            end
        endcase

        // Pin outputs are derived from the next state so they register with it
        tms_d = 1'b0;
        tdi_d = 1'b0;
        case (state_d)
            INIT:                 tms_d = (cnt_d < 4'd5);
`ifdef JTAG_SEQ_RESET_CMD_EN
            RST_SEQ:              tms_d = (cnt_d < 4'd5);
`endif
            SEL_DR, SEL_IR, EXIT1: tms_d = 1'b1;
            SHIFT: begin
                tms_d = (cnt_d == len_d);
                tdi_d = data_d[cnt_d];
            end
            default: ;
        endcase
        busy_d      = (state_d != IDLE);
        rsp_valid_d = (state_d == RSP);
        cmd_ready_d = (state_d == IDLE) && !rsp_valid_d;
    end

    always_ff @(posedge TCK) begin
        if (!TRST_b) begin
            state_q     <= INIT;
            cnt_q       <= '0;
            ir_q        <= 1'b0;
            len_q       <= '0;
            data_q      <= '0;
            rsp_data_q  <= '0;
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b0;
            tms_q       <= 1'b1;
            tdi_q       <= 1'b0;
            busy_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ir_q        <= ir_d;
            len_q       <= len_d;
            data_q      <= data_d;
            rsp_data_q  <= rsp_data_d;
            rsp_valid_q <= rsp_valid_d;
            cmd_ready_q <= cmd_ready_d;
            tms_q       <= tms_d;
            tdi_q       <= tdi_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.cmd_ready = cmd_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign TMS           = tms_q;
    assign TDI           = tdi_q;
    assign busy          = busy_q;
endmodule

// File: tb/tb_jtag_seq_master.sv
// Bench for jtag_seq_master: a trace model builds the expected per-cycle pin/handshake
// sequence for each command; a compare process checks the DUT against it every cycle.
module tb_jtag_seq_master;
    logic       TCK = 1'b0;
    logic       TRST_b;
    logic       TMS, TDI, TDO, busy;
    logic [1:0] tdo_mode;           // 0: tied 0, 1: tied 1, 2: TDI delayed one cycle
    logic       tdi_d1 = 1'b0;

    jtag_seq_master_if bus ();

    jtag_seq_master dut (
        .TCK    (TCK),
        .TRST_b (TRST_b),
        .bus    (bus.slave),
        .TMS    (TMS),
        .TDI    (TDI),
        .TDO    (TDO),
        .busy   (busy)
    );

    always #5 TCK = ~TCK;

    always_ff @(posedge TCK) tdi_d1 <= TDI;
    assign TDO = (tdo_mode == 2'd2) ? tdi_d1 : tdo_mode[0];

    typedef struct {
        logic        tms;
        logic        tdi;
        logic        busy;
        logic        rdy;
        logic        rv;
        logic        chk_rd;
        logic [15:0] rd;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mdl_q[$];
    int unsigned mdl_lat;
    logic [15:0] mdl_rsp;
    int          n_tests = 0;
    int          n_fail  = 0;

    function automatic void check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic exp_t mk(input logic tms, input logic tdi, input logic bsy,
                                input logic rdy, input logic rv, input logic chk,
                                input logic [15:0] rd);
        exp_t e;
        e.tms = tms; e.tdi = tdi; e.busy = bsy; e.rdy = rdy;
        e.rv = rv; e.chk_rd = chk; e.rd = rd;
        return e;
    endfunction

    // Trace model: entry 0 is the accepting IDLE cycle, entries 1..mdl_lat precede RSP.
    task automatic model_cmd(input logic [1:0] typ, input logic [3:0] len, input logic [15:0] data,
                             input logic [1:0] mode, input int unsigned wait_cyc,
                             input int unsigned tail);
        int unsigned n;
        logic        prev;
        logic [15:0] rsp;
        mdl_q.delete();
        rsp  = '0;
        prev = 1'b0;
        mdl_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0));
        if (typ[1]) begin
`ifdef JTAG_SEQ_RESET_CMD_EN
            for (int i = 0; i < 5; i++) mdl_q.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0));
            mdl_q.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0));
`endif
        end else begin
            mdl_q.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0));
            if (typ[0]) mdl_q.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0));
            mdl_q.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0));
            mdl_q.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0));
            n = 32'(len) + 1;
            for (int unsigned k = 0; k < n; k++) begin
                mdl_q.push_back(mk(k == n - 1, data[k], 1'b1, 1'b0, 1'b0, 1'b0, 16'h0));
                rsp[k] = (mode == 2'd2) ? prev : mode[0];
                prev   = data[k];
            end
            mdl_q.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0));
            mdl_q.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0));
        end
        mdl_lat = mdl_q.size() - 1;
        mdl_rsp = rsp;
        for (int unsigned i = 0; i <= wait_cyc; i++) mdl_q.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, rsp));
        for (int unsigned i = 0; i < tail; i++) mdl_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0));
    endtask

    function automatic logic [15:0] mdl_tms_bits();
        logic [15:0] v = '0;
        for (int unsigned i = 1; i <= mdl_lat; i++) v = {v[14:0], mdl_q[i].tms};
        return v;
    endfunction

    function automatic logic [15:0] mdl_tdi_bits();
        logic [15:0] v = '0;
        for (int unsigned i = 1; i <= mdl_lat; i++) v = {v[14:0], mdl_q[i].tdi};
        return v;
    endfunction

    task automatic push_init();
        for (int i = 0; i < 5; i++) exp_q.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0));
        exp_q.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0));
    endtask

    task automatic step();
        @(posedge TCK);
        #1;
    endtask

    task automatic start_cmd(input logic [1:0] typ, input logic [3:0] len, input logic [15:0] data,
                             input logic [1:0] mode);
        tdo_mode      = mode;
        bus.cmd_valid = 1'b1;
        bus.cmd_type  = typ;
        bus.cmd_len   = len;
        bus.cmd_data  = data;
        step();
        // Scramble the command inputs to prove they were latched at acceptance
        bus.cmd_valid = 1'b0;
        bus.cmd_type  = ~typ;
        bus.cmd_len   = ~len;
        bus.cmd_data  = ~data;
    endtask

    task automatic run_cmd(input logic [1:0] typ, input logic [3:0] len, input logic [15:0] data,
                           input logic [1:0] mode, input int unsigned wait_cyc, input bit early_rdy,
                           input bit poke, input int unsigned tail, output logic [15:0] seen);
        model_cmd(typ, len, data, mode, wait_cyc, tail);
        foreach (mdl_q[i]) exp_q.push_back(mdl_q[i]);
        start_cmd(typ, len, data, mode);
        if (early_rdy) bus.rsp_ready = 1'b1;
        repeat (mdl_lat) step();
        seen = bus.rsp_data;
        if (poke) begin
            bus.cmd_valid = 1'b1;
            bus.cmd_type  = 2'b00;
            bus.cmd_len   = 4'd2;
            bus.cmd_data  = 16'h5A5A;
        end
        repeat (wait_cyc) step();
        bus.cmd_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        step();
        bus.rsp_ready = 1'b0;
        repeat (tail) step();
    endtask

    always @(negedge TCK) begin : cmp_blk
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("TMS",       {15'b0, TMS},           {15'b0, e.tms});
            check("TDI",       {15'b0, TDI},           {15'b0, e.tdi});
            check("busy",      {15'b0, busy},          {15'b0, e.busy});
            check("cmd_ready", {15'b0, bus.cmd_ready}, {15'b0, e.rdy});
            check("rsp_valid", {15'b0, bus.rsp_valid}, {15'b0, e.rv});
            if (e.rv || e.chk_rd) check("rsp_data", bus.rsp_data, e.rd);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] seen;
        TRST_b        = 1'b0;
        tdo_mode      = 2'd0;
        bus.cmd_valid = 1'b0;
        bus.cmd_type  = 2'b00;
        bus.cmd_len   = 4'd0;
        bus.cmd_data  = 16'h0;
        bus.rsp_ready = 1'b0;
        repeat (3) step();

        TRST_b = 1'b1;
        push_init();
        repeat (5) step();
        check("init_tms_cyc6", {15'b0, TMS}, 16'h0000);
        check("init_rdy_cyc6", {15'b0, bus.cmd_ready}, 16'h0000);
        step();
        check("init_rdy_cyc7", {15'b0, bus.cmd_ready}, 16'h0001);

        // Pin the model against hand-derived sequences
        model_cmd(2'b00, 4'd7, 16'h00A5, 2'd2, 0, 0);
        check("mdl_dr_tms", mdl_tms_bits(), 16'h1006);
        check("mdl_dr_tdi", mdl_tdi_bits(), 16'h0294);
        check("mdl_dr_lat", 16'(mdl_lat), 16'd13);
        check("mdl_dr_rsp", mdl_rsp, 16'h004A);
        model_cmd(2'b01, 4'd1, 16'h0002, 2'd1, 0, 0);
        check("mdl_ir_tms", mdl_tms_bits(), 16'h00C6);
        check("mdl_ir_lat", 16'(mdl_lat), 16'd8);
        check("mdl_ir_rsp", mdl_rsp, 16'h0003);

        run_cmd(2'b00, 4'd7,  16'h00A5, 2'd2, 0,  1'b0, 1'b0, 1, seen);
        check("dr8_loop_rsp", seen, 16'h004A);
        run_cmd(2'b01, 4'd1,  16'h0002, 2'd1, 0,  1'b1, 1'b0, 1, seen);
        check("ir2_tdo1_rsp", seen, 16'h0003);
        run_cmd(2'b00, 4'd15, 16'hFFFF, 2'd0, 0,  1'b0, 1'b0, 1, seen);
        check("dr16_tdo0_rsp", seen, 16'h0000);
        run_cmd(2'b00, 4'd3,  16'h000B, 2'd2, 10, 1'b0, 1'b1, 3, seen);
        check("dr4_stall_rsp", seen, 16'h0006);
        run_cmd(2'b10, 4'd9,  16'hBEEF, 2'd1, 1,  1'b0, 1'b0, 1, seen);
        check("type1x_rsp", seen, 16'h0000);
        run_cmd(2'b01, 4'd15, 16'h1234, 2'd2, 0,  1'b0, 1'b0, 1, seen);
        check("ir16_loop_rsp", seen, 16'h2468);

        // Abort a 16-bit scan with a reset pulse during shift cycle 3
        model_cmd(2'b00, 4'd15, 16'hC3A5, 2'd2, 0, 0);
        for (int unsigned i = 0; i < 8; i++) exp_q.push_back(mdl_q[i]);
        start_cmd(2'b00, 4'd15, 16'hC3A5, 2'd2);
        repeat (6) step();
        TRST_b = 1'b0;
        step();
        TRST_b = 1'b1;
        push_init();
        repeat (6) step();
        check("abort_rdy", {15'b0, bus.cmd_ready}, 16'h0001);

        run_cmd(2'b00, 4'd0, 16'h0001, 2'd1, 0, 1'b0, 1'b0, 2, seen);
        check("dr1_tdo1_rsp", seen, 16'h0001);

        for (int i = 0; i < 50 && exp_q.size() > 0; i++) step();
        check("trace_drained", 16'(exp_q.size()), 16'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
